// File: rtl/gat_ctrl_pkg.sv
// Shared constants for the GAT run controller: default sizing and the 3-bit state encoding.
package gat_ctrl_pkg;

    localparam int DEF_TOP_WIDTH          = 32;
    localparam int DEF_NEW_FEATURE_WIDTH  = 32;
    localparam int DEF_NUM_SUBGRAPHS      = 2708;
    localparam int DEF_NUM_FEATURE_OUT    = 16;
    localparam int DEF_NEW_FEATURE_DEPTH  = DEF_NUM_SUBGRAPHS * DEF_NUM_FEATURE_OUT;
    localparam int DEF_NEW_FEATURE_ADDR_W = $clog2(DEF_NEW_FEATURE_DEPTH);
    localparam int DEF_TIMEOUT_CYCLES     = 100000000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_LOAD = 3'd1;
    localparam state_t ST_RUN       = 3'd2;
    localparam state_t ST_READOUT   = 3'd3;
    localparam state_t ST_DONE      = 3'd4;
    localparam state_t ST_ERROR     = 3'd5;

    // Watchdog counter only has to hold limit-1.
    function automatic int wdog_width(input int limit);
        return (limit > 2) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/gat_skid_fifo.sv
// Two-entry FIFO buffering BRAM read data (word + last flag) ahead of the host stream.
module gat_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gat_run_ctrl.sv
// Run sequencer: gates start on BRAM load flags, watches the accelerator with a watchdog,
// then streams the new-feature BRAM to the host through a 2-entry FIFO.
module gat_run_ctrl
    import gat_ctrl_pkg::*;
#(
    parameter int TOP_WIDTH          = DEF_TOP_WIDTH,
    parameter int NEW_FEATURE_WIDTH  = DEF_NEW_FEATURE_WIDTH,
    parameter int NUM_SUBGRAPHS      = DEF_NUM_SUBGRAPHS,
    parameter int NUM_FEATURE_OUT    = DEF_NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          h_data_bram_load_done,
    input  logic                          h_node_info_bram_load_done,
    input  logic                          wgt_bram_load_done,
    input  logic                          subgraph_bram_load_done,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err_timeout,
    output logic [TOP_WIDTH-1:0]          cycle_count,
    output logic [2:0]                    state_dbg
);

    localparam int WDOG_W = wdog_width(TIMEOUT_CYCLES);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX   = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [WDOG_W-1:0]             WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_t                        state_q, state_d;
    logic [NEW_FEATURE_ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic                          issued_all_q, issued_all_d;
    logic                          inflight_q, inflight_last_q;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic [TOP_WIDTH-1:0]          cyc_q, cyc_d;
    logic [WDOG_W-1:0]             wdog_q, wdog_d;

    logic                          all_loaded;
    logic                          issue;
    logic                          pop;
    logic                          flush;
    logic [2:0]                    occ;
    logic [1:0]                    fifo_count;
    logic [NEW_FEATURE_WIDTH:0]    fifo_head;

    assign all_loaded = h_data_bram_load_done & h_node_info_bram_load_done
                      & wgt_bram_load_done & subgraph_bram_load_done;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Count the word leaving this cycle as free, so sustained ready keeps 1 word/cycle.
    assign occ   = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == ST_READOUT) && !issued_all_q && (occ < 3'd2);

    always_comb begin
        state_d      = state_q;
        rd_idx_d     = rd_idx_q;
        issued_all_d = issued_all_q;
        done_d       = done_q;
        err_d        = err_q;
        cyc_d        = cyc_q;
        wdog_d       = wdog_q;
        flush        = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_WAIT_LOAD;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    cyc_d        = '0;
                    wdog_d       = '0;
                    rd_idx_d     = '0;
                    issued_all_d = 1'b0;
                    flush        = 1'b1;
                end
            end
            ST_WAIT_LOAD: begin
                if (all_loaded) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cyc_q != '1) begin
                    cyc_d = cyc_q + 1'b1;
                end
                wdog_d = wdog_q + 1'b1;
                if (gat_ready) begin
                    state_d = ST_READOUT;
                end else if (wdog_q == WDOG_LIMIT) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end
            end
            ST_READOUT: begin
                if (issue) begin
                    if (rd_idx_q == LAST_IDX) begin
                        issued_all_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                if (pop && fifo_head[NEW_FEATURE_WIDTH]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rd_idx_q        <= '0;
            issued_all_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            cyc_q           <= '0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            rd_idx_q        <= rd_idx_d;
            issued_all_q    <= issued_all_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rd_idx_q == LAST_IDX);
            done_q          <= done_d;
            err_q           <= err_d;
            cyc_q           <= cyc_d;
            wdog_q          <= wdog_d;
        end
    end

    // BRAM data for a read issued last cycle is valid now; capture it with its last flag.
    gat_skid_fifo #(
        .W(NEW_FEATURE_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, feat_bram_dout}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign feat_bram_addrb = {rd_idx_q, 2'b00};
    assign out_data        = fifo_head[NEW_FEATURE_WIDTH-1:0];
    assign out_last        = out_valid & fifo_head[NEW_FEATURE_WIDTH];
    assign busy            = (state_q == ST_WAIT_LOAD) || (state_q == ST_RUN) || (state_q == ST_READOUT);
    assign done            = done_q;
    assign err_timeout     = err_q;
    assign cycle_count     = cyc_q;
    assign state_dbg       = state_q;

endmodule

// File: doc/gat_run_ctrl.md
Name: gat_run_ctrl

Overview:
- Run-sequencing controller between the host register bank and the GAT accelerator top.
- Gates start on all BRAM load-done flags and monitors the accelerator's ready flag with a watchdog.
- After completion, sweeps the new-feature BRAM read port (byte addressed, step 4) and streams results to the host over a valid/ready interface with backpressure.
- Exposes busy/done/timeout status and a run-cycle counter for the debug registers.

Parameters:
- TOP_WIDTH, 32, host data/status word width
- NEW_FEATURE_WIDTH, 32, feature BRAM word width
- NUM_SUBGRAPHS, 2708, number of subgraphs
- NUM_FEATURE_OUT, 16, output features per subgraph
- NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, words to read out
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), word-address width
- TIMEOUT_CYCLES, 100000000, watchdog limit in RUN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle run request from the register bank
- h_data_bram_load_done  in  1  level
- h_node_info_bram_load_done  in  1  level
- wgt_bram_load_done  in  1  level
- subgraph_bram_load_done  in  1  level
- gat_ready  in  1  accelerator finished (level)
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address, [1:0]=0
- feat_bram_dout  in  NEW_FEATURE_WIDTH  read data, 1-cycle latency
- out_data  out  NEW_FEATURE_WIDTH  streamed feature word
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts
- out_last  out  1  final word marker
- busy  out  1  state not IDLE/DONE
- done  out  1  sticky until next start
- err_timeout  out  1  sticky watchdog flag
- cycle_count  out  TOP_WIDTH  cycles spent in RUN
- state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, feat_bram_addrb=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, err_timeout=0, cycle_count=0.
- States (encoding): IDLE=0, WAIT_LOAD=1, RUN=2, READOUT=3, DONE=4, ERROR=5.
- IDLE: start -> WAIT_LOAD; clear done, err_timeout, cycle_count, read address, buffer.
- WAIT_LOAD: when the AND of all four load_done flags is high -> RUN (one cycle later). No timeout in this state.
- RUN:
  - cycle_count increments every cycle (saturates at all-ones).
  - gat_ready high -> READOUT.
  - Watchdog counter reaching TIMEOUT_CYCLES-1 without gat_ready -> ERROR, err_timeout=1.
  - gat_ready and the timeout in the same cycle: gat_ready wins.
- READOUT:
  - Word index rd_idx runs 0..NEW_FEATURE_DEPTH-1; feat_bram_addrb = {rd_idx,2'b00}.
  - A read issues only when buffered words plus in-flight reads < 2. Data is captured into a 2-entry FIFO one cycle after issue.
  - out_valid = FIFO non-empty; pop on out_valid & out_ready.
  - out_last = 1 with the word for index NEW_FEATURE_DEPTH-1.
  - Sustained out_ready=1 yields 1 word/cycle after 2-cycle startup latency (issue -> capture -> out_valid).
  - rd_idx never wraps: no issue after the last index. Leave READOUT on the handshake of the last word -> DONE.
- DONE: done=1, busy=0. A new start -> WAIT_LOAD; it is ignored in the same cycle as the DONE entry.
- ERROR: busy=0, err_timeout=1. Only start (-> WAIT_LOAD, flags cleared) or rst leaves it.
- start while busy: ignored.
- Load flag deasserted mid-RUN: ignored (flags are sampled only in WAIT_LOAD).
- rst mid-READOUT: FIFO flushed, all outputs to reset values immediately.
- out_ready held low: address and FIFO hold; no word is dropped or duplicated.

Decomposition:
- Package gat_ctrl_pkg holds the state enum (3-bit encoding above) and localparams derived from NEW_FEATURE_DEPTH/ADDR_W.
- Sub-module gat_skid_fifo: 2-entry, NEW_FEATURE_WIDTH+1 wide (data + last), push/pop/count, async active-high reset. Instantiate once.

Test Plan (NUM_SUBGRAPHS=2, NUM_FEATURE_OUT=4, TIMEOUT_CYCLES=50; BRAM model dout = addr*3):
- Load gating: start, then raise the four load flags at cycles 3, 5, 7, 9 -> state_dbg=1 until cycle 10, then 2.
- Full run: gat_ready high after 20 cycles in RUN, out_ready=1.
  - Expect cycle_count=20.
  - Expect addresses 0, 4, …, 28.
  - Expect out_data 0, 12, …, 84 on consecutive cycles; out_last on the 8th word; done=1, busy=0.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> exactly 8 words in order, no duplicates, at most 2 reads outstanding+buffered.
- Timeout: gat_ready held low -> ERROR after 50 RUN cycles, err_timeout=1. A subsequent start clears it and re-enters WAIT_LOAD.
- Simultaneous event: gat_ready asserted on cycle 50 of RUN -> READOUT, err_timeout stays 0.
- Reset mid-READOUT: assert rst after 3 words -> out_valid=0, state_dbg=0, feat_bram_addrb=0 in the same cycle; the next run streams from word 0.
